// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit serializer: start, 5-8 data bits LSB first, optional parity, 1/2 stop bits
module uart_tx_engine #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_tx_i,
  input  logic [7:0] tx_data_i,
  input  logic [1:0] data_bit_num_i,
  input  logic       stop_bit_num_i,
  input  logic       parity_en_i,
  input  logic       parity_type_i,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       nbits_q, nbits_d;
  logic             stop2_q, stop2_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             start_q, start_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             start_pulse;
  logic             bit_end;
  logic [7:0]       data_mask;

  // Next-state logic: start-edge detection, bit timing, frame sequencing and the registered line value
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    nbits_d     = nbits_q;
    stop2_d     = stop2_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop_cnt_d  = stop_cnt_q;
    start_d     = start_tx_i;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    start_pulse = start_tx_i & ~start_q;
    bit_end     = (baud_cnt_q == BAUD_LAST);

    // Only the N payload bits take part in parity; the upper bits are masked off
    case (data_bit_num_i)
      2'b00:   data_mask = 8'h1F;
      2'b01:   data_mask = 8'h3F;
      2'b10:   data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (start_pulse) begin
          // Whole frame configuration is captured here so later input changes are ignored
          state_d    = START;
          shift_d    = tx_data_i;
          nbits_d    = data_bit_num_i;
          stop2_d    = stop_bit_num_i;
          par_en_d   = parity_en_i;
          par_bit_d  = (^(tx_data_i & data_mask)) ^ parity_type_i;
          bit_idx_d  = 3'd0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          tx_d       = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          // Last index is N-1, i.e. 4 + data_bit_num
          if (bit_idx_q == {1'b1, nbits_q}) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          baud_cnt_d = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset aborts any frame and returns the line to idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      nbits_q    <= 2'b00;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_cnt_q <= 1'b0;
      start_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      nbits_q    <= nbits_d;
      stop2_q    <= stop2_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop_cnt_q <= stop_cnt_d;
      start_q    <= start_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;

endmodule
